// File: rtl/register_file_pkg.sv
// -----------------------------------------------------------------------------
// register_file_pkg
// Shared types and constants for the parametrised register file.
//   RF_OP_W : width of the write-port operation code
//   rf_op_t : write-port operation (NOP, WRITE, ADD, CLEAR)
// -----------------------------------------------------------------------------
package register_file_pkg;

  localparam int RF_OP_W = 2;

  typedef enum logic [RF_OP_W-1:0] {
    RF_NOP   = 2'b00,
    RF_WRITE = 2'b01,
    RF_ADD   = 2'b10,
    RF_CLEAR = 2'b11
  } rf_op_t;

endpackage

// File: rtl/register_file_next_value.sv
// -----------------------------------------------------------------------------
// register_file_next_value
// Computes the value a WRITE or ADD would store into the addressed register.
// The state update and the read bypass both use this block, so the value that
// is bypassed is always the value that lands in the register.
// Ports:
//   op          in   current write-port operation
//   is_zero_idx in   write index is register 0
//   cur_data    in   current contents of the addressed register
//   port_write  in   write data / addend
//   next_data   out  value to store (sum wraps modulo 2^WIDTH for ADD)
//   next_carry  out  carry-out of the ADD (0 for other ops)
//   write_en    out  the op really changes the addressed register
// -----------------------------------------------------------------------------
module register_file_next_value
  import register_file_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter bit ZERO_REG = 1'b0
) (
  input  rf_op_t           op,
  input  logic             is_zero_idx,
  input  logic [WIDTH-1:0] cur_data,
  input  logic [WIDTH-1:0] port_write,
  output logic [WIDTH-1:0] next_data,
  output logic             next_carry,
  output logic             write_en
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum        = {1'b0, cur_data} + {1'b0, port_write};
    next_data  = cur_data;
    next_carry = 1'b0;
    write_en   = 1'b0;
    case (op)
      RF_WRITE: begin
        next_data = port_write;
        write_en  = 1'b1;
      end
      RF_ADD: begin
        next_data  = sum[WIDTH-1:0];
        next_carry = sum[WIDTH];
        write_en   = 1'b1;
      end
      default: ;
    endcase
    // A hard-wired zero register swallows writes and adds entirely,
    // which also suppresses the carry update and the bypass.
    if (ZERO_REG && is_zero_idx) begin
      write_en = 1'b0;
    end
  end

endmodule

// File: rtl/register_file_param.sv
// -----------------------------------------------------------------------------
// register_file_param
// DEPTH x WIDTH register file with two combinational read ports and one
// op-coded synchronous write port (NOP, WRITE, ADD, CLEAR), optional
// same-cycle read bypass, optional hard-wired zero register and a registered
// carry flag from the last effective ADD.
// Ports:
//   i_clk          in   rising-edge clock
//   i_rst_n        in   asynchronous active-low reset
//   i_reg_read_0   in   register index for read port 0
//   i_reg_read_1   in   register index for read port 1
//   i_reg_write    in   register index for WRITE/ADD
//   i_port_write   in   write data / addend
//   i_op           in   rf_op_t operation code
//   o_port_read_0  out  data of i_reg_read_0
//   o_port_read_1  out  data of i_reg_read_1
//   o_carry        out  carry-out of the last effective ADD
// -----------------------------------------------------------------------------
module register_file_param
  import register_file_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 4,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [$clog2(DEPTH)-1:0] i_reg_read_0,
  input  logic [$clog2(DEPTH)-1:0] i_reg_read_1,
  input  logic [$clog2(DEPTH)-1:0] i_reg_write,
  input  logic [WIDTH-1:0]         i_port_write,
  input  logic [RF_OP_W-1:0]       i_op,
  output logic [WIDTH-1:0]         o_port_read_0,
  output logic [WIDTH-1:0]         o_port_read_1,
  output logic                     o_carry
);

  localparam int AW = $clog2(DEPTH);

  if (WIDTH < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
    $error("register_file_param: DEPTH must be a power of two >= 2 and WIDTH >= 1");
  end

  rf_op_t           op;
  logic [WIDTH-1:0] reg_file_reg [DEPTH];
  logic             carry_reg;
  logic [WIDTH-1:0] nv_data;
  logic             nv_carry;
  logic             nv_we;

  assign op = rf_op_t'(i_op);

  register_file_next_value #(
    .WIDTH    (WIDTH),
    .ZERO_REG (ZERO_REG)
  ) u_next_value (
    .op          (op),
    .is_zero_idx (i_reg_write == '0),
    .cur_data    (reg_file_reg[i_reg_write]),
    .port_write  (i_port_write),
    .next_data   (nv_data),
    .next_carry  (nv_carry),
    .write_en    (nv_we)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) reg_file_reg[i] <= '0;
      carry_reg <= 1'b0;
    end else if (op == RF_CLEAR) begin
      for (int i = 0; i < DEPTH; i++) reg_file_reg[i] <= '0;
      carry_reg <= 1'b0;
    end else if (nv_we) begin
      reg_file_reg[i_reg_write] <= nv_data;
      if (op == RF_ADD) carry_reg <= nv_carry;
    end
  end

  // Read path: stored value, optionally overridden by the in-flight result.
  // Reset is folded in so the ports read 0 even while a bypassing op is
  // presented during reset.
  function automatic logic [WIDTH-1:0] read_value(input logic [AW-1:0] idx);
    logic [WIDTH-1:0] value;
    value = reg_file_reg[idx];
    if (BYPASS && op == RF_CLEAR) begin
      value = '0;
    end else if (BYPASS && nv_we && idx == i_reg_write) begin
      value = nv_data;
    end
    if (!i_rst_n || (ZERO_REG && idx == '0)) begin
      value = '0;
    end
    return value;
  endfunction

  assign o_port_read_0 = read_value(i_reg_read_0);
  assign o_port_read_1 = read_value(i_reg_read_1);
  assign o_carry       = carry_reg;

endmodule

// File: tb/tb_register_file_param.sv
// -----------------------------------------------------------------------------
// tb_register_file_param
// Drives three register files in parallel from the same inputs:
//   index 0: BYPASS=1 ZERO_REG=0, index 1: BYPASS=0 ZERO_REG=0,
//   index 2: BYPASS=1 ZERO_REG=1
// and compares every output against a behavioural model of each variant.
// -----------------------------------------------------------------------------
module tb_register_file_param;
  import register_file_pkg::*;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] rd0   = '0;
  logic [1:0] rd1   = '0;
  logic [1:0] wr    = '0;
  logic [1:0] op    = '0;
  logic [3:0] wd    = '0;

  logic [3:0] q0 [3];
  logic [3:0] q1 [3];
  logic       cy [3];

  int total = 0;
  int bad   = 0;

  // Model state: register contents and carry per variant.
  int mr [3][4];
  int mc [3];

  always #5 clk = ~clk;

  register_file_param #(.WIDTH(4), .DEPTH(4), .BYPASS(1'b1), .ZERO_REG(1'b0)) dut_byp (
    .i_clk(clk), .i_rst_n(rst_n), .i_reg_read_0(rd0), .i_reg_read_1(rd1),
    .i_reg_write(wr), .i_port_write(wd), .i_op(op),
    .o_port_read_0(q0[0]), .o_port_read_1(q1[0]), .o_carry(cy[0]));

  register_file_param #(.WIDTH(4), .DEPTH(4), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut_nob (
    .i_clk(clk), .i_rst_n(rst_n), .i_reg_read_0(rd0), .i_reg_read_1(rd1),
    .i_reg_write(wr), .i_port_write(wd), .i_op(op),
    .o_port_read_0(q0[1]), .o_port_read_1(q1[1]), .o_carry(cy[1]));

  register_file_param #(.WIDTH(4), .DEPTH(4), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_zero (
    .i_clk(clk), .i_rst_n(rst_n), .i_reg_read_0(rd0), .i_reg_read_1(rd1),
    .i_reg_write(wr), .i_port_write(wd), .i_op(op),
    .o_port_read_0(q0[2]), .o_port_read_1(q1[2]), .o_carry(cy[2]));

  // ---------------- reference model ----------------
  function automatic bit has_bypass(int v);
    return v != 1;
  endfunction

  function automatic bit has_zero(int v);
    return v == 2;
  endfunction

  function automatic bit writes(int v);
    return (op == 2'd1 || op == 2'd2) && !(has_zero(v) && wr == 2'd0);
  endfunction

  function automatic logic [3:0] exp_rd(int v, int idx);
    int s;
    if (!rst_n) return 4'h0;
    if (has_zero(v) && idx == 0) return 4'h0;
    if (has_bypass(v) && op == 2'd3) return 4'h0;
    if (has_bypass(v) && writes(v) && idx == int'(wr)) begin
      if (op == 2'd1) return wd;
      s = (mr[v][wr] + int'(wd)) % 16;
      return 4'(s);
    end
    return 4'(mr[v][idx]);
  endfunction

  task automatic model_edge();
    int s;
    for (int v = 0; v < 3; v++) begin
      if (op == 2'd3) begin
        for (int i = 0; i < 4; i++) mr[v][i] = 0;
        mc[v] = 0;
      end else if (writes(v)) begin
        if (op == 2'd1) begin
          mr[v][wr] = int'(wd);
        end else begin
          s = mr[v][wr] + int'(wd);
          mr[v][wr] = s % 16;
          mc[v] = (s >= 16) ? 1 : 0;
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < 4; i++) mr[v][i] = 0;
      mc[v] = 0;
    end
  endtask

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic drive(input int o, input int w, input int d, input int r0, input int r1);
    op  = 2'(o);
    wr  = 2'(w);
    wd  = 4'(d);
    rd0 = 2'(r0);
    rd1 = 2'(r1);
    $display("txn t=%0t rst_n=%0b op=%0d w=%0d d=%h r0=%0d r1=%0d", $time, rst_n, o, w, d, r0, r1);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int rows [4][5] = '{'{0,0,0,0,1}, '{0,0,0,2,3}, '{2,1,5,1,1}, '{1,3,7,3,0}};
    model_reset();
    for (int r = 0; r < 4; r++) begin
      drive(rows[r][0], rows[r][1], rows[r][2], rows[r][3], rows[r][4]);
      for (int v = 0; v < 3; v++) begin
        total += 3;
        if (q0[v] !== 4'h0) begin bad++; $display("FAIL reset v%0d port0 got=%h want=0", v, q0[v]); end
        if (q1[v] !== 4'h0) begin bad++; $display("FAIL reset v%0d port1 got=%h want=0", v, q1[v]); end
        if (cy[v] !== 1'b0) begin bad++; $display("FAIL reset v%0d carry got=%b want=0", v, cy[v]); end
      end
      step();
    end
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  task automatic test_write_bypass();
    int rows [2][5] = '{'{1,2,10,2,3}, '{0,0,0,2,3}};
    for (int r = 0; r < 2; r++) begin
      drive(rows[r][0], rows[r][1], rows[r][2], rows[r][3], rows[r][4]);
      for (int v = 0; v < 3; v++) begin
        total += 3;
        if (q0[v] !== exp_rd(v, int'(rd0))) begin bad++; $display("FAIL write_bypass v%0d port0 got=%h want=%h", v, q0[v], exp_rd(v, int'(rd0))); end
        if (q1[v] !== exp_rd(v, int'(rd1))) begin bad++; $display("FAIL write_bypass v%0d port1 got=%h want=%h", v, q1[v], exp_rd(v, int'(rd1))); end
        if (cy[v] !== 1'(mc[v])) begin bad++; $display("FAIL write_bypass v%0d carry got=%b want=%0d", v, cy[v], mc[v]); end
      end
      step();
    end
  endtask

  task automatic test_add_carry();
    int rows [4][5] = '{'{1,1,14,1,0}, '{2,1,3,1,2}, '{2,1,2,1,1}, '{0,0,0,1,1}};
    for (int r = 0; r < 4; r++) begin
      drive(rows[r][0], rows[r][1], rows[r][2], rows[r][3], rows[r][4]);
      for (int v = 0; v < 3; v++) begin
        total += 3;
        if (q0[v] !== exp_rd(v, int'(rd0))) begin bad++; $display("FAIL add_carry v%0d port0 got=%h want=%h", v, q0[v], exp_rd(v, int'(rd0))); end
        if (q1[v] !== exp_rd(v, int'(rd1))) begin bad++; $display("FAIL add_carry v%0d port1 got=%h want=%h", v, q1[v], exp_rd(v, int'(rd1))); end
        if (cy[v] !== 1'(mc[v])) begin bad++; $display("FAIL add_carry v%0d carry got=%b want=%0d", v, cy[v], mc[v]); end
      end
      step();
    end
    // Plain-number cross-check of the documented sequence: r1 ends at 0x3, carry 0.
    total += 2;
    if (q0[0] !== 4'h3) begin bad++; $display("FAIL add_carry_final r1 got=%h want=3", q0[0]); end
    if (cy[0] !== 1'b0) begin bad++; $display("FAIL add_carry_final carry got=%b want=0", cy[0]); end
  endtask

  task automatic test_back_to_back();
    int rows [5][5] = '{'{2,3,5,3,3}, '{2,3,5,3,0}, '{2,3,5,3,3}, '{2,3,5,0,3}, '{0,0,0,3,3}};
    for (int r = 0; r < 5; r++) begin
      drive(rows[r][0], rows[r][1], rows[r][2], rows[r][3], rows[r][4]);
      for (int v = 0; v < 3; v++) begin
        total += 3;
        if (q0[v] !== exp_rd(v, int'(rd0))) begin bad++; $display("FAIL back_to_back v%0d port0 got=%h want=%h", v, q0[v], exp_rd(v, int'(rd0))); end
        if (q1[v] !== exp_rd(v, int'(rd1))) begin bad++; $display("FAIL back_to_back v%0d port1 got=%h want=%h", v, q1[v], exp_rd(v, int'(rd1))); end
        if (cy[v] !== 1'(mc[v])) begin bad++; $display("FAIL back_to_back v%0d carry got=%b want=%0d", v, cy[v], mc[v]); end
      end
      step();
    end
    // Four adds of 5 from 0: 5, A, F, then 0x14 wraps to 4 with carry.
    total += 2;
    if (q1[1] !== 4'h4) begin bad++; $display("FAIL back_to_back_final r3 got=%h want=4", q1[1]); end
    if (cy[1] !== 1'b1) begin bad++; $display("FAIL back_to_back_final carry got=%b want=1", cy[1]); end
  endtask

  task automatic test_clear();
    int rows [9][5] = '{'{1,0,1,0,1}, '{1,1,2,0,1}, '{1,2,3,2,3}, '{1,3,15,2,3}, '{2,3,5,3,3},
                        '{3,2,9,0,3}, '{0,0,0,0,1}, '{0,0,0,2,3}, '{1,1,6,1,0}};
    for (int r = 0; r < 9; r++) begin
      drive(rows[r][0], rows[r][1], rows[r][2], rows[r][3], rows[r][4]);
      for (int v = 0; v < 3; v++) begin
        total += 3;
        if (q0[v] !== exp_rd(v, int'(rd0))) begin bad++; $display("FAIL clear v%0d port0 got=%h want=%h", v, q0[v], exp_rd(v, int'(rd0))); end
        if (q1[v] !== exp_rd(v, int'(rd1))) begin bad++; $display("FAIL clear v%0d port1 got=%h want=%h", v, q1[v], exp_rd(v, int'(rd1))); end
        if (cy[v] !== 1'(mc[v])) begin bad++; $display("FAIL clear v%0d carry got=%b want=%0d", v, cy[v], mc[v]); end
      end
      step();
    end
  endtask

  task automatic test_zero_reg();
    int rows [6][5] = '{'{1,1,15,1,0}, '{2,1,1,1,0}, '{1,0,7,0,0}, '{2,0,15,0,1}, '{1,1,7,0,1}, '{0,0,0,0,1}};
    for (int r = 0; r < 6; r++) begin
      drive(rows[r][0], rows[r][1], rows[r][2], rows[r][3], rows[r][4]);
      for (int v = 0; v < 3; v++) begin
        total += 3;
        if (q0[v] !== exp_rd(v, int'(rd0))) begin bad++; $display("FAIL zero_reg v%0d port0 got=%h want=%h", v, q0[v], exp_rd(v, int'(rd0))); end
        if (q1[v] !== exp_rd(v, int'(rd1))) begin bad++; $display("FAIL zero_reg v%0d port1 got=%h want=%h", v, q1[v], exp_rd(v, int'(rd1))); end
        if (cy[v] !== 1'(mc[v])) begin bad++; $display("FAIL zero_reg v%0d carry got=%b want=%0d", v, cy[v], mc[v]); end
      end
      step();
    end
  endtask

  task automatic test_random();
    int o;
    for (int n = 0; n < 60; n++) begin
      o = int'($urandom_range(0, 9));
      o = (o == 9) ? 3 : (o % 3);
      drive(o, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      for (int v = 0; v < 3; v++) begin
        total += 3;
        if (q0[v] !== exp_rd(v, int'(rd0))) begin bad++; $display("FAIL random v%0d port0 got=%h want=%h", v, q0[v], exp_rd(v, int'(rd0))); end
        if (q1[v] !== exp_rd(v, int'(rd1))) begin bad++; $display("FAIL random v%0d port1 got=%h want=%h", v, q1[v], exp_rd(v, int'(rd1))); end
        if (cy[v] !== 1'(mc[v])) begin bad++; $display("FAIL random v%0d carry got=%b want=%0d", v, cy[v], mc[v]); end
      end
      step();
    end
  endtask

  task automatic test_reset_mid_add();
    drive(1, 2, 9, 2, 2);
    step();
    drive(2, 2, 3, 2, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int v = 0; v < 3; v++) begin
      total += 3;
      if (q0[v] !== 4'h0) begin bad++; $display("FAIL reset_mid_add v%0d port0 got=%h want=0", v, q0[v]); end
      if (q1[v] !== 4'h0) begin bad++; $display("FAIL reset_mid_add v%0d port1 got=%h want=0", v, q1[v]); end
      if (cy[v] !== 1'b0) begin bad++; $display("FAIL reset_mid_add v%0d carry got=%b want=0", v, cy[v]); end
    end
    step();
    drive(0, 0, 0, 2, 1);
    rst_n = 1'b1;
    #1;
    for (int v = 0; v < 3; v++) begin
      total += 3;
      if (q0[v] !== exp_rd(v, int'(rd0))) begin bad++; $display("FAIL after_reset v%0d port0 got=%h want=%h", v, q0[v], exp_rd(v, int'(rd0))); end
      if (q1[v] !== exp_rd(v, int'(rd1))) begin bad++; $display("FAIL after_reset v%0d port1 got=%h want=%h", v, q1[v], exp_rd(v, int'(rd1))); end
      if (cy[v] !== 1'(mc[v])) begin bad++; $display("FAIL after_reset v%0d carry got=%b want=%0d", v, cy[v], mc[v]); end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_add_carry();
    test_back_to_back();
    test_clear();
    test_zero_reg();
    test_random();
    test_reset_mid_add();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/register_file_param.md
Name: register_file_param

Overview:
- Parametrised successor of the team's 4x4-bit register file: DEPTH registers of WIDTH bits, two combinational read ports, one synchronous write port.
- Adds an op-coded write port (plain write, accumulate-add, clear-all), optional same-cycle read bypass, optional hard-wired zero register, and a registered carry flag.
- Sits under the DE10-Lite top level in place of the fixed 4-register file, and is reused as the operand store for later datapath blocks.

Parameters:
- WIDTH, 4, data bits per register (>=1).
- DEPTH, 4, number of registers; power of two, >=2; address width AW = $clog2(DEPTH).
- BYPASS, 1, 1: a read of the register being written this cycle returns the value being written; 0: it returns the stored (old) value.
- ZERO_REG, 0, 1: register 0 always reads 0 and ignores every write/add.

Ports:
- i_clk  in  1  rising-edge clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_reg_read_0  in  AW  register index for read port 0.
- i_reg_read_1  in  AW  register index for read port 1.
- i_reg_write  in  AW  register index for write/add.
- i_port_write  in  WIDTH  write data / addend.
- i_op  in  2  rf_op_t: 00 NOP, 01 WRITE, 10 ADD, 11 CLEAR.
- o_port_read_0  out  WIDTH  data of i_reg_read_0.
- o_port_read_1  out  WIDTH  data of i_reg_read_1.
- o_carry  out  1  registered carry-out of the last effective ADD.

Behaviour:
- Reset (i_rst_n=0, asynchronous): all registers <= 0, o_carry <= 0. While held in reset, read ports return 0. Deassertion takes effect at the next rising edge; ops sampled on that edge execute.
- Reads are combinational from the current state and index, subject to BYPASS and ZERO_REG.
- NOP: state and o_carry hold.
- WRITE: reg[i_reg_write] <= i_port_write at the rising edge; o_carry holds.
- ADD: {c, s} = reg[w] + i_port_write, computed in WIDTH+1 bits.
  - reg[w] <= s, which wraps modulo 2^WIDTH.
  - o_carry <= c.
  - Latency 1 cycle. Back-to-back ADDs to the same register accumulate; each uses the value stored after the previous edge.
- CLEAR: all registers <= 0, o_carry <= 0 in one edge; i_reg_write and i_port_write are ignored.
- BYPASS=1, op is WRITE or ADD, and read index == i_reg_write:
  - That read port returns the next value in the same cycle (i_port_write for WRITE, s for ADD).
  - During CLEAR, both read ports return 0.
  - Both ports may bypass at once.
- BYPASS=0: reads always show stored state; a new value is visible from the cycle after the edge.
- ZERO_REG=1:
  - Reads of index 0 return 0.
  - WRITE/ADD to index 0 are no-ops: no state change, o_carry holds, no bypass.
  - CLEAR is unaffected.
- Writes to one index never disturb other registers.
- Illegal parameters (DEPTH not a power of two, WIDTH<1) are rejected by an elaboration-time assertion.

Decomposition:
- Package register_file_pkg:
  - rf_op_t enum (RF_NOP, RF_WRITE, RF_ADD, RF_CLEAR).
  - Op-width constant RF_OP_W=2.
- Sub-module register_file_next_value: combinational block.
  - Inputs: op, current reg[w], i_port_write.
  - Outputs: next data value, carry, write-effective flag (applies the ZERO_REG mask).
  - Shared by the state update and the bypass path so both always agree.

Test Plan (WIDTH=4, DEPTH=4, BYPASS=1, ZERO_REG=0 unless stated):
- Reset then read all indices -> every read returns 0, o_carry=0. Assert i_rst_n mid-ADD between edges -> outputs 0 immediately, no write lands.
- WRITE r2=0xA, then read_0=2, read_1=3 -> 0xA and 0x0. During the write cycle with read_0=2 -> 0xA (bypass). Repeat with BYPASS=0 -> old 0x0 shown during the write cycle, 0xA after the edge.
- WRITE r1=0xE, ADD r1 +0x3 -> r1=0x1, o_carry=1. Next ADD r1 +0x2 -> r1=0x3, o_carry=0.
- Three consecutive ADDs of 0x5 to r3 from 0 -> r3 = 0x5, 0xA, 0xF; o_carry stays 0. A fourth ADD -> r3=0x4, o_carry=1.
- Load r0..r3 = 1,2,3,4 with o_carry=1, then CLEAR -> the cycle after, all reads 0 and o_carry=0. During the CLEAR cycle, bypassed reads return 0.
- ZERO_REG=1: WRITE r0=0x7 and ADD r0 +0xF -> r0 reads 0, o_carry unchanged. Meanwhile a WRITE r1=0x7 lands normally.
